minmax_frame_tracker: RTL and testbench

- Downstream consumer of the 16-bit magnitude-compare function.
- Accepts a valid/ready stream of unsigned samples and groups them into fixed-length frames.
- Per frame it keeps a running maximum and minimum, each with the in-frame index where it first occurred, using unsigned greater-than/less-than compares.
- Emits one registered result per frame on a valid/ready output port for statistics and threshold logic further down the chain.

---
 rtl/minmax_frame_tracker_if.sv | 32 +++
 rtl/minmax_frame_tracker.sv | 172 +++++++++++++++++
 tb/tb_minmax_frame_tracker.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/minmax_frame_tracker_if.sv
// Stream interface for the min/max frame tracker: sample input and per-frame result output.
interface minmax_frame_tracker_if #(
    parameter int WIDTH     = 16,
    parameter int FRAME_LEN = 8
) ();
    localparam int IDX_W = $clog2(FRAME_LEN);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_max;
    logic [WIDTH-1:0] out_min;
    logic [IDX_W-1:0] out_max_idx;
    logic [IDX_W-1:0] out_min_idx;
    logic             out_all_equal;

    // Producer side: drives samples and accepts results.
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_max, out_min,
               out_max_idx, out_min_idx, out_all_equal
    );

    // Tracker side: consumes samples and presents results.
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_max, out_min,
               out_max_idx, out_min_idx, out_all_equal
    );
endinterface

// File: rtl/minmax_frame_tracker.sv
// Groups an unsigned sample stream into fixed-length frames and reports, per frame,
// the maximum and minimum with the index of their first occurrence.
module minmax_frame_tracker #(
    parameter int   WIDTH     = 16,
    parameter int   FRAME_LEN = 8,
    localparam int  IDX_W     = $clog2(FRAME_LEN)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    minmax_frame_tracker_if.slave  bus
);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    state_t           state_q, state_d;
    logic             alive_q, alive_d;
    logic [IDX_W-1:0] count_q, count_d;

    logic [WIDTH-1:0] run_max_q, run_max_d;
    logic [WIDTH-1:0] run_min_q, run_min_d;
    logic [IDX_W-1:0] run_max_idx_q, run_max_idx_d;
    logic [IDX_W-1:0] run_min_idx_q, run_min_idx_d;

    logic [WIDTH-1:0] out_max_q, out_max_d;
    logic [WIDTH-1:0] out_min_q, out_min_d;
    logic [IDX_W-1:0] out_max_idx_q, out_max_idx_d;
    logic [IDX_W-1:0] out_min_idx_q, out_min_idx_d;
    logic             out_all_equal_q, out_all_equal_d;

    logic             in_ready;
    logic             out_valid;
    logic             take;
    logic             last_take;

    logic [WIDTH-1:0] cand_max, cand_min;
    logic [IDX_W-1:0] cand_max_idx, cand_min_idx;

    // A sample counts only when handshaken and not dropped by a same-cycle flush.
    assign take      = bus.in_valid && in_ready && !flush;
    assign last_take = take && (count_q == LAST_IDX);

    // State register; alive_q keeps in_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCUM;
            alive_q <= 1'b0;
        end else begin
            state_q <= state_d;
            alive_q <= alive_d;
        end
    end

    // Next-state: finish a frame into HOLD, leave HOLD when the result is taken.
    always_comb begin
        state_d = state_q;
        alive_d = 1'b1;
        case (state_q)
            ACCUM:   if (last_take)     state_d = HOLD;
            HOLD:    if (bus.out_ready) state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
    end

    // FSM outputs: accept samples only while accumulating, present a result while holding.
    always_comb begin
        in_ready  = alive_q && (state_q == ACCUM);
        out_valid = (state_q == HOLD);
    end

    // Candidate extremes including the current sample; strict compares keep the earliest index on ties.
    always_comb begin
        cand_max     = run_max_q;
        cand_min     = run_min_q;
        cand_max_idx = run_max_idx_q;
        cand_min_idx = run_min_idx_q;
        if (count_q == '0) begin
            cand_max     = bus.in_data;
            cand_min     = bus.in_data;
            cand_max_idx = '0;
            cand_min_idx = '0;
        end else begin
            if (bus.in_data > run_max_q) begin
                cand_max     = bus.in_data;
                cand_max_idx = count_q;
            end
            if (bus.in_data < run_min_q) begin
                cand_min     = bus.in_data;
                cand_min_idx = count_q;
            end
        end
    end

    // Running accumulator and sample counter; flush abandons the partial frame.
    always_comb begin
        count_d       = count_q;
        run_max_d     = run_max_q;
        run_min_d     = run_min_q;
        run_max_idx_d = run_max_idx_q;
        run_min_idx_d = run_min_idx_q;
        if ((state_q == ACCUM) && flush) begin
            count_d       = '0;
            run_max_d     = '0;
            run_min_d     = '0;
            run_max_idx_d = '0;
            run_min_idx_d = '0;
        end else if (take) begin
            count_d       = last_take ? '0 : count_q + IDX_W'(1);
            run_max_d     = cand_max;
            run_min_d     = cand_min;
            run_max_idx_d = cand_max_idx;
            run_min_idx_d = cand_min_idx;
        end
    end

    // Result registers load only when a frame completes and otherwise keep the last result.
    always_comb begin
        out_max_d       = out_max_q;
        out_min_d       = out_min_q;
        out_max_idx_d   = out_max_idx_q;
        out_min_idx_d   = out_min_idx_q;
        out_all_equal_d = out_all_equal_q;
        if (last_take) begin
            out_max_d       = cand_max;
            out_min_d       = cand_min;
            out_max_idx_d   = cand_max_idx;
            out_min_idx_d   = cand_min_idx;
            out_all_equal_d = (cand_max == cand_min);
        end
    end

    // Datapath registers for the accumulator and the published result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q         <= '0;
            run_max_q       <= '0;
            run_min_q       <= '0;
            run_max_idx_q   <= '0;
            run_min_idx_q   <= '0;
            out_max_q       <= '0;
            out_min_q       <= '0;
            out_max_idx_q   <= '0;
            out_min_idx_q   <= '0;
            out_all_equal_q <= 1'b0;
        end else begin
            count_q         <= count_d;
            run_max_q       <= run_max_d;
            run_min_q       <= run_min_d;
            run_max_idx_q   <= run_max_idx_d;
            run_min_idx_q   <= run_min_idx_d;
            out_max_q       <= out_max_d;
            out_min_q       <= out_min_d;
            out_max_idx_q   <= out_max_idx_d;
            out_min_idx_q   <= out_min_idx_d;
            out_all_equal_q <= out_all_equal_d;
        end
    end

    assign bus.in_ready      = in_ready;
    assign bus.out_valid     = out_valid;
    assign bus.out_max       = out_max_q;
    assign bus.out_min       = out_min_q;
    assign bus.out_max_idx   = out_max_idx_q;
    assign bus.out_min_idx   = out_min_idx_q;
    assign bus.out_all_equal = out_all_equal_q;

endmodule

// File: tb/tb_minmax_frame_tracker.sv
// Directed bench for minmax_frame_tracker with FRAME_LEN=4: vector table plus corner-case sequences.
module tb_minmax_frame_tracker;

    localparam int WIDTH     = 16;
    localparam int FRAME_LEN = 4;
    localparam int NUM_VEC   = 7;

    logic clk;
    logic rst_n;
    logic flush;

    int checks = 0;
    int errors = 0;

    minmax_frame_tracker_if #(.WIDTH(WIDTH), .FRAME_LEN(FRAME_LEN)) bus ();

    minmax_frame_tracker #(.WIDTH(WIDTH), .FRAME_LEN(FRAME_LEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    typedef struct {
        logic [15:0] samples [FRAME_LEN];
        logic [15:0] expMax;
        logic [1:0]  expMaxIdx;
        logic [15:0] expMin;
        logic [1:0]  expMinIdx;
        logic        expAllEqual;
    } vec_t;

    vec_t vectors [NUM_VEC];

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic setVec(input int i, input logic [15:0] s0, input logic [15:0] s1,
                          input logic [15:0] s2, input logic [15:0] s3,
                          input logic [15:0] mx, input logic [1:0] mxi,
                          input logic [15:0] mn, input logic [1:0] mni, input logic eq);
        vectors[i].samples[0]  = s0;
        vectors[i].samples[1]  = s1;
        vectors[i].samples[2]  = s2;
        vectors[i].samples[3]  = s3;
        vectors[i].expMax      = mx;
        vectors[i].expMaxIdx   = mxi;
        vectors[i].expMin      = mn;
        vectors[i].expMinIdx   = mni;
        vectors[i].expAllEqual = eq;
    endtask

    // Presents one sample and holds it until the DUT accepts it (bounded wait).
    task automatic sendSample(input logic [15:0] d);
        int waitCount = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        while (!bus.in_ready && waitCount < 20) begin
            tick();
            waitCount++;
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL sendReady actual=0 expected=1");
        end
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        for (int i = 0; i < FRAME_LEN; i++) sendSample(v.samples[i]);
    endtask

    task automatic checkFrame(input string tag, input logic [15:0] mx, input logic [1:0] mxi,
                              input logic [15:0] mn, input logic [1:0] mni, input logic eq);
        checkOutput({tag, ".out_valid"}, {31'd0, bus.out_valid}, 32'd1);
        checkOutput({tag, ".max"}, {16'd0, bus.out_max}, {16'd0, mx});
        checkOutput({tag, ".max_idx"}, {30'd0, bus.out_max_idx}, {30'd0, mxi});
        checkOutput({tag, ".min"}, {16'd0, bus.out_min}, {16'd0, mn});
        checkOutput({tag, ".min_idx"}, {30'd0, bus.out_min_idx}, {30'd0, mni});
        checkOutput({tag, ".all_equal"}, {31'd0, bus.out_all_equal}, {31'd0, eq});
    endtask

    task automatic checkCleared(input string tag);
        checkOutput({tag, ".out_valid"}, {31'd0, bus.out_valid}, 32'd0);
        checkOutput({tag, ".in_ready"}, {31'd0, bus.in_ready}, 32'd0);
        checkOutput({tag, ".max"}, {16'd0, bus.out_max}, 32'd0);
        checkOutput({tag, ".min"}, {16'd0, bus.out_min}, 32'd0);
        checkOutput({tag, ".max_idx"}, {30'd0, bus.out_max_idx}, 32'd0);
        checkOutput({tag, ".min_idx"}, {30'd0, bus.out_min_idx}, 32'd0);
        checkOutput({tag, ".all_equal"}, {31'd0, bus.out_all_equal}, 32'd0);
    endtask

    // Main sequence: reset, vector table, then backpressure, flush and reset corner cases.
    initial begin
        setVec(0, 16'h0001, 16'hFFFF, 16'h1234, 16'hABCD, 16'hFFFF, 2'd1, 16'h0001, 2'd0, 1'b0);
        setVec(1, 16'h1234, 16'h1234, 16'h1234, 16'h1234, 16'h1234, 2'd0, 16'h1234, 2'd0, 1'b1);
        setVec(2, 16'h0005, 16'h0009, 16'h0009, 16'h0002, 16'h0009, 2'd1, 16'h0002, 2'd3, 1'b0);
        setVec(3, 16'h7FFF, 16'hFFFF, 16'h7FFF, 16'h0000, 16'hFFFF, 2'd1, 16'h0000, 2'd3, 1'b0);
        setVec(4, 16'h0004, 16'h0003, 16'h0002, 16'h0001, 16'h0004, 2'd0, 16'h0001, 2'd3, 1'b0);
        setVec(5, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 2'd0, 16'h0000, 2'd0, 1'b1);
        setVec(6, 16'h0003, 16'h0001, 16'h0007, 16'h0001, 16'h0007, 2'd2, 16'h0001, 2'd1, 1'b0);

        rst_n         = 1'b0;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;

        repeat (3) tick();
        checkCleared("reset");
        rst_n = 1'b1;
        #1;
        checkOutput("release.in_ready_before_edge", {31'd0, bus.in_ready}, 32'd0);
        tick();
        checkOutput("release.in_ready_after_edge", {31'd0, bus.in_ready}, 32'd1);

        // Table: back-to-back frames with the consumer always ready.
        for (int i = 0; i < NUM_VEC; i++) begin
            applyStimulus(vectors[i]);
            checkFrame($sformatf("vec%0d", i), vectors[i].expMax, vectors[i].expMaxIdx,
                       vectors[i].expMin, vectors[i].expMinIdx, vectors[i].expAllEqual);
            checkOutput($sformatf("vec%0d.in_ready_hold", i), {31'd0, bus.in_ready}, 32'd0);
            tick();
            checkOutput($sformatf("vec%0d.out_valid_drop", i), {31'd0, bus.out_valid}, 32'd0);
            checkOutput($sformatf("vec%0d.in_ready_back", i), {31'd0, bus.in_ready}, 32'd1);
        end

        // Backpressure: result and outputs frozen for 5 cycles; an offered sample is ignored.
        bus.out_ready = 1'b0;
        sendSample(16'h0100);
        sendSample(16'h0050);
        sendSample(16'h0200);
        sendSample(16'h0075);
        bus.in_valid = 1'b1;
        bus.in_data  = 16'hFFFF;
        for (int c = 0; c < 5; c++) begin
            checkFrame($sformatf("bp%0d", c), 16'h0200, 2'd2, 16'h0050, 2'd1, 1'b0);
            checkOutput($sformatf("bp%0d.in_ready", c), {31'd0, bus.in_ready}, 32'd0);
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        checkOutput("bp.out_valid_drop", {31'd0, bus.out_valid}, 32'd0);
        checkOutput("bp.in_ready_back", {31'd0, bus.in_ready}, 32'd1);
        checkOutput("bp.max_retained", {16'd0, bus.out_max}, 32'h0200);

        // Flush in ACCUM after two samples, with a sample offered in the flush cycle.
        sendSample(16'hFFFF);
        sendSample(16'h0000);
        flush        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h0001;
        tick();
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        sendSample(16'h0010);
        sendSample(16'h0020);
        sendSample(16'h0030);
        sendSample(16'h0040);
        checkFrame("flush", 16'h0040, 2'd3, 16'h0010, 2'd0, 1'b0);
        tick();

        // Flush in HOLD leaves the pending result intact.
        bus.out_ready = 1'b0;
        sendSample(16'h0002);
        sendSample(16'h0008);
        sendSample(16'h0004);
        sendSample(16'h0006);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checkFrame("flushHold", 16'h0008, 2'd1, 16'h0002, 2'd0, 1'b0);
        bus.out_ready = 1'b1;
        tick();
        checkOutput("flushHold.out_valid_drop", {31'd0, bus.out_valid}, 32'd0);

        // Reset after three samples of a frame: cleared at once, then a full frame is needed.
        sendSample(16'h0011);
        sendSample(16'h0022);
        sendSample(16'h0033);
        rst_n = 1'b0;
        #1;
        checkCleared("rstMid");
        tick();
        rst_n = 1'b1;
        tick();
        sendSample(16'h0100);
        sendSample(16'h0200);
        sendSample(16'h0300);
        checkOutput("rstMid.no_early_valid", {31'd0, bus.out_valid}, 32'd0);
        sendSample(16'h0050);
        checkFrame("rstMid.frame", 16'h0300, 2'd2, 16'h0050, 2'd3, 1'b0);
        tick();

        // Reset while holding an unaccepted result.
        bus.out_ready = 1'b0;
        sendSample(16'h0009);
        sendSample(16'h0008);
        sendSample(16'h0007);
        sendSample(16'h0006);
        checkFrame("rstHold.pre", 16'h0009, 2'd0, 16'h0006, 2'd3, 1'b0);
        rst_n = 1'b0;
        #1;
        checkCleared("rstHold");
        tick();
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        checkOutput("rstHold.in_ready_back", {31'd0, bus.in_ready}, 32'd1);
        checkOutput("rstHold.out_valid_low", {31'd0, bus.out_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
